uart_tx_framer: RTL and testbench

//  Parametrised UART transmitter. Serialises DATA_BITS-wide words LSB-first.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_framer.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit path.
package uart_pkg;

   // Legal range for the number of data bits in a frame.
   localparam int MIN_DATA_BITS = 5;
   localparam int MAX_DATA_BITS = 9;

   // Width of the data-bit counter, wide enough for the largest legal word.
   localparam int BIT_CNT_W = $clog2(MAX_DATA_BITS);

   // Transmit frame phases.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Frame format, captured once per frame so mid-frame changes cannot corrupt it.
   typedef struct packed {
      logic parity_en;
      logic parity_odd;
      logic two_stop;
   } uart_frame_cfg_t;

   // XOR of all data bits; unused upper bits are zero and do not disturb the result.
   function automatic logic word_parity(input logic [MAX_DATA_BITS-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversampling baud ticks and flags the tick that closes one bit period.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic baud_tick,
   input  logic enable,
   input  logic clear,
   output logic bit_end
);

   localparam int               CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(OVERSAMPLE - 1);

   generate
      if (OVERSAMPLE < 2) begin : g_bad_oversample
         $error("uart_bit_timer: OVERSAMPLE must be at least 2");
      end
   endgenerate

   logic [CNT_W-1:0] tick_cnt;

   // Ticks only count while a frame is running, so idle ticks never shorten a start bit.
   assign bit_end = enable && baud_tick && (tick_cnt == LAST);

   // Tick counter: cleared on frame start, wraps at the end of every bit.
   always_ff @(posedge Clk or posedge Reset) begin
      // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values regardless of statement order.
      if (Reset) begin
         tick_cnt <= '0;
      end else if (clear) begin
         tick_cnt <= '0;
      end else if (enable && baud_tick) begin
         tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// with a one-word holding register so frames can follow each other without a gap.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 cfg_parity_en,
   input  logic                 cfg_parity_odd,
   input  logic                 cfg_two_stop,
   output logic                 UART_TX_I,
   output logic                 busy,
   output logic                 frame_done
);

   generate
      if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
         $error("uart_tx_framer: DATA_BITS must be within 5..9");
      end
   endgenerate

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

   tx_state_t             state_q, state_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   uart_frame_cfg_t       cfg_q, cfg_d;
   logic                  data_par_q, data_par_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;

   logic                  accept;
   logic                  load;
   logic [DATA_BITS-1:0]  load_word;
   logic                  bit_end;

   // Ready depends only on the holding register, never on s_valid.
   assign s_ready    = ~hold_valid_q;
   assign accept     = s_valid & s_ready;
   assign busy       = (state_q != IDLE);
   assign UART_TX_I  = tx_q;
   assign frame_done = done_q;

   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .Clk       (Clk),
      .Reset     (Reset),
      .baud_tick (baud_tick),
      .enable    (busy),
      .clear     (load),
      .bit_end   (bit_end)
   );

   // Frame sequencing, holding-register management and next line level.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can leave it holding a value and infer a latch.
      state_d      = state_q;
      shift_d      = shift_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      cfg_d        = cfg_q;
      data_par_d   = data_par_q;
      done_d       = 1'b0;
      load         = 1'b0;
      load_word    = s_data;

      case (state_q)
         IDLE: begin
            // An accepted word bypasses the holding register and starts at once.
            if (accept) begin
               load      = 1'b1;
               load_word = s_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_d    = cfg_q.parity_en ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (cfg_q.two_stop && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  // A waiting word starts on this same edge: no idle cycle between frames.
                  if (hold_valid_q) begin
                     load         = 1'b1;
                     load_word    = hold_data_q;
                     hold_valid_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Words accepted mid-frame park in the holding register; ready drops next cycle.
      // An unload and a new accept never coincide because ready is low while it is full.
      if (accept && state_q != IDLE) begin
         hold_data_d  = s_data;
         hold_valid_d = 1'b1;
      end

      // Frame start: capture word and format together so the whole frame is self-consistent.
      if (load) begin
         state_d          = START;
         shift_d          = load_word;
         cfg_d.parity_en  = cfg_parity_en;
         cfg_d.parity_odd = cfg_parity_odd;
         cfg_d.two_stop   = cfg_two_stop;
         data_par_d       = word_parity(MAX_DATA_BITS'(load_word));
         bit_cnt_d        = '0;
         stop_cnt_d       = 1'b0;
      end

      // Line level for the cycle after this edge, derived from where the frame goes next.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = data_par_d ^ cfg_d.parity_odd;
         default: tx_d = 1'b1;
      endcase
   end

   // State, datapath and registered line output; reset forces the line high at once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         // NOTE: the data registers are reset as well as their valid flags so a frame dropped by reset leaves no stale word behind.
         shift_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         cfg_q        <= '0;
         data_par_q   <= 1'b0;
         tx_q         <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         cfg_q        <= cfg_d;
         data_par_q   <= data_par_d;
         tx_q         <= tx_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: an 8-bit instance with a tick every cycle
// and a 5-bit instance with a tick every 4th cycle, checked against a tick-counting
// frame model built from the serial frame format.
module tb_uart_tx_framer;

   localparam int OS = 16;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       tick8, tick5;
   logic [7:0] s_data8;
   logic [4:0] s_data5;
   logic       s_valid8, s_valid5;
   logic       cfg_parity_en, cfg_parity_odd, cfg_two_stop;
   logic       ready8, ready5, tx8, tx5, busy8, busy5, done8, done5;

   logic       use5;
   logic       mon_tx, mon_busy, mon_done, mon_ready, mon_tick;
   int         errors = 0;
   int         checks = 0;
   int         div = 0;

   assign mon_tx    = use5 ? tx5    : tx8;
   assign mon_busy  = use5 ? busy5  : busy8;
   assign mon_done  = use5 ? done5  : done8;
   assign mon_ready = use5 ? ready5 : ready8;
   assign mon_tick  = use5 ? tick5  : tick8;

   uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut8 (
      .Clk(Clk), .Reset(Reset), .baud_tick(tick8),
      .s_data(s_data8), .s_valid(s_valid8), .s_ready(ready8),
      .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
      .UART_TX_I(tx8), .busy(busy8), .frame_done(done8)
   );

   uart_tx_framer #(.DATA_BITS(5), .OVERSAMPLE(OS)) dut5 (
      .Clk(Clk), .Reset(Reset), .baud_tick(tick5),
      .s_data(s_data5), .s_valid(s_valid5), .s_ready(ready5),
      .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
      .UART_TX_I(tx5), .busy(busy5), .frame_done(done5)
   );

   always #5 Clk = ~Clk;

   // Free-running tick every 4th cycle, changed just after the rising edge.
   initial begin
      tick5 = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         div   = (div + 1) % 4;
         tick5 = (div == 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a word on the selected instance, wait (bounded) for ready, complete the handshake.
   // Called at a falling edge; returns at the falling edge right after the accepting edge.
   task automatic send(input int word);
      int budget = 0;
      if (use5) begin
         s_data5  = 5'(word);
         s_valid5 = 1'b1;
      end else begin
         s_data8  = 8'(word);
         s_valid8 = 1'b1;
      end
      while (mon_ready !== 1'b1 && budget < 3000) begin
         @(negedge Clk);
         budget++;
      end
      check("s_ready before accept", mon_ready, 1);
      @(negedge Clk);
      s_valid8 = 1'b0;
      s_valid5 = 1'b0;
   endtask

   // Model: the frame is a list of bit values; bit k occupies the cycles after the
   // accepting edge while the number of ticks seen is in [k*OS, (k+1)*OS).
   task automatic expect_frame(input string tag, input int word, input int nd,
                               input bit pe, input bit po, input bit ts, input bit more);
      bit bits[$];
      int ones = 0;
      int ticks = 0;
      int cyc = 0;
      int cur = 0;
      int bad = 0;
      int stray_done = 0;
      int idle_cycles = 0;
      int idx = 0;
      bit timed_out = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < nd; i++) begin
         bits.push_back(bit'((word >> i) & 1));
         ones += (word >> i) & 1;
      end
      if (pe) bits.push_back(po ? bit'((ones + 1) % 2) : bit'(ones % 2));
      bits.push_back(1'b1);
      if (ts) bits.push_back(1'b1);
      while (1) begin
         idx = ticks / OS;
         if (idx != cur) begin
            check($sformatf("%s bit%0d wrong cycles", tag, cur), bad, 0);
            bad = 0;
            cur = idx;
         end
         if (idx >= bits.size()) break;
         if (cyc >= 3000) begin
            timed_out = 1'b1;
            break;
         end
         if (mon_tx !== bits[idx]) bad++;
         if (cyc > 0 && mon_done !== 1'b0) stray_done++;
         if (mon_busy !== 1'b1) idle_cycles++;
         if (mon_tick === 1'b1) ticks++;
         cyc++;
         @(negedge Clk);
      end
      check($sformatf("%s timeout", tag), timed_out, 0);
      check($sformatf("%s frame_done at end", tag), mon_done, 1);
      check($sformatf("%s busy after end", tag), mon_busy, more);
      check($sformatf("%s early frame_done", tag), stray_done, 0);
      check($sformatf("%s busy dropped", tag), idle_cycles, 0);
   endtask

   initial begin
      int w, pe, po, ts;
      Reset          = 1'b1;
      tick8          = 1'b1;
      use5           = 1'b0;
      s_data8        = '0;
      s_data5        = '0;
      s_valid8       = 1'b0;
      s_valid5       = 1'b0;
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;
      cfg_two_stop   = 1'b0;

      repeat (3) @(negedge Clk);
      check("reset tx8", tx8, 1);
      check("reset ready8", ready8, 1);
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset tx5", tx5, 1);
      check("reset ready5", ready5, 1);
      Reset = 1'b0;
      repeat (20) @(negedge Clk);
      check("idle tx8", tx8, 1);
      check("idle busy8", busy8, 0);

      // 8N1 0xA5
      send('hA5);
      expect_frame("8N1 A5", 'hA5, 8, 0, 0, 0, 0);
      check("idle line after A5", tx8, 1);

      // Even and odd parity on 0x07
      repeat (3) @(negedge Clk);
      cfg_parity_en = 1'b1;
      cfg_parity_odd = 1'b0;
      send('h07);
      expect_frame("8E1 07", 'h07, 8, 1, 0, 0, 0);
      cfg_parity_odd = 1'b1;
      send('h07);
      expect_frame("8O1 07", 'h07, 8, 1, 1, 0, 0);

      // Two stop bits, configuration toggled mid-frame must not matter
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;
      cfg_two_stop   = 1'b1;
      send('h00);
      fork
         expect_frame("8N2 00 cfg toggle", 'h00, 8, 0, 0, 1, 0);
         begin
            repeat (30) @(negedge Clk);
            cfg_two_stop   = 1'b0;
            cfg_parity_en  = 1'b1;
            cfg_parity_odd = 1'b1;
         end
      join
      cfg_two_stop   = 1'b0;
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;

      // Back-to-back 0x55 then 0xAA through the holding register
      repeat (2) @(negedge Clk);
      s_data8  = 8'h55;
      s_valid8 = 1'b1;
      @(negedge Clk);
      fork
         begin
            expect_frame("b2b 55", 'h55, 8, 0, 0, 0, 1);
            expect_frame("b2b AA", 'hAA, 8, 0, 0, 0, 0);
         end
         begin
            s_data8 = 8'hAA;
            @(negedge Clk);
            check("ready low while hold full", ready8, 0);
            s_valid8 = 1'b0;
            repeat (158) @(negedge Clk);
            check("ready low before unload", ready8, 0);
            @(negedge Clk);
            check("ready high after unload", ready8, 1);
         end
      join

      // Reset during data bit 3 of 0xC3 (bit 3 is a zero, so the line is low)
      repeat (4) @(negedge Clk);
      send('hC3);
      repeat (70) @(negedge Clk);
      check("line low before reset", tx8, 0);
      Reset = 1'b1;
      #1;
      check("reset mid-frame tx", tx8, 1);
      check("reset mid-frame ready", ready8, 1);
      check("reset mid-frame busy", busy8, 0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("idle after reset", tx8, 1);
      send('h3C);
      expect_frame("after reset 3C", 'h3C, 8, 0, 0, 0, 0);

      // Random 8-bit frames with random format
      for (int n = 0; n < 6; n++) begin
         w  = int'($urandom_range(0, 255));
         pe = int'($urandom_range(0, 1));
         po = int'($urandom_range(0, 1));
         ts = int'($urandom_range(0, 1));
         cfg_parity_en  = pe[0];
         cfg_parity_odd = po[0];
         cfg_two_stop   = ts[0];
         repeat ($urandom_range(0, 3)) @(negedge Clk);
         send(w);
         expect_frame($sformatf("rand8 #%0d %0h", n, w), w, 8, pe[0], po[0], ts[0], 0);
      end

      // 5-bit instance, slow ticks, random idle gaps so idle ticks land at random phase
      use5 = 1'b1;
      for (int n = 0; n < 3; n++) begin
         w  = int'($urandom_range(0, 31));
         pe = int'($urandom_range(0, 1));
         po = int'($urandom_range(0, 1));
         ts = int'($urandom_range(0, 1));
         cfg_parity_en  = pe[0];
         cfg_parity_odd = po[0];
         cfg_two_stop   = ts[0];
         repeat ($urandom_range(5, 40)) @(negedge Clk);
         send(w);
         expect_frame($sformatf("rand5 #%0d %0h", n, w), w, 5, pe[0], po[0], ts[0], 0);
      end
      check("idle tx5", tx5, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
